// File: rtl/sine_wave_generator_multichannel.sv
// sine_wave_generator_multichannel: N-channel quarter-wave DDS with per-channel offset/gain,
// global phase sync and a dwell-based linear frequency sweep engine.
module sine_wave_generator_multichannel #(
    parameter int CHANNELS          = 2,
    parameter int PHASE_WIDTH       = 32,
    parameter int LUT_ADDRESS_WIDTH = 8,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int AMPLITUDE_WIDTH   = 16
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic                                  phase_sync,
    input  logic [CHANNELS*PHASE_WIDTH-1:0]       phase_step,
    input  logic [CHANNELS*PHASE_WIDTH-1:0]       phase_offset,
    input  logic [CHANNELS*AMPLITUDE_WIDTH-1:0]   amplitude,
    input  logic                                  sweep_enable,
    input  logic [PHASE_WIDTH-1:0]                sweep_increment,
    input  logic [PHASE_WIDTH-1:0]                sweep_limit,
    input  logic [31:0]                           sweep_dwell,
    output logic [CHANNELS*OUTPUT_WIDTH-1:0]      generated_wave,
    output logic                                  wave_valid,
    output logic [CHANNELS-1:0]                   sweep_wrap
);
    localparam int PW = PHASE_WIDTH;
    localparam int LW = LUT_ADDRESS_WIDTH;
    localparam int OW = OUTPUT_WIDTH;
    localparam int AW = AMPLITUDE_WIDTH;
    localparam logic [AW-1:0] UNITY = {1'b1, {(AW-1){1'b0}}};

    // Half-sample offset keeps the four quadrants exactly symmetric; folds to a ROM.
    function automatic logic signed [OW-1:0] lut_val(input int k);
        real x;
        x = (2.0 ** (OW - 1) - 1.0) * $sin(3.141592653589793 / 2.0 * (real'(k) + 0.5) / 2.0 ** LW);
        return OW'($rtoi(x + 0.5));
    endfunction

    logic signed [OW-1:0] lut [1 << LW];

    for (genvar k = 0; k < (1 << LW); k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    logic [PW-1:0]        step_q [CHANNELS];
    logic [PW-1:0]        step_d [CHANNELS];
    logic [PW-1:0]        acc_q  [CHANNELS];
    logic [PW-1:0]        acc_d  [CHANNELS];
    logic [LW+1:0]        s1_q   [CHANNELS];
    logic [LW+1:0]        s1_d   [CHANNELS];
    logic [1:0]           quad_q [CHANNELS];
    logic [1:0]           quad_d [CHANNELS];
    logic signed [OW-1:0] s2_q   [CHANNELS];
    logic signed [OW-1:0] s2_d   [CHANNELS];
    logic signed [OW-1:0] s3_q   [CHANNELS];
    logic signed [OW-1:0] s3_d   [CHANNELS];
    logic signed [OW-1:0] y_q    [CHANNELS];
    logic signed [OW-1:0] y_d    [CHANNELS];
    logic [CHANNELS-1:0]  wrap_q, wrap_d;
    logic [31:0]          dwell_q, dwell_d, dwell_max;
    logic                 sweep_q, sweep_rise, dwell_term;
    logic [3:0]           valid_q;

    always_comb begin
        logic [PW-1:0]        base;
        logic [PW:0]          sum;
        logic                 over;
        logic [1:0]           quad;
        logic [LW-1:0]        idx;
        logic [AW-1:0]        amp;
        logic signed [OW+AW:0] prod;
        dwell_max  = (sweep_dwell == 32'd0) ? 32'd0 : sweep_dwell - 32'd1;
        sweep_rise = sweep_enable && !sweep_q;
        dwell_term = dwell_q == dwell_max;
        dwell_d    = (sweep_enable && !sweep_rise && !dwell_term) ? dwell_q + 32'd1 : 32'd0;
        wrap_d     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            base       = phase_step[c*PW +: PW];
            sum        = {1'b0, step_q[c]} + {1'b0, sweep_increment};
            over       = sum > {1'b0, sweep_limit};
            step_d[c]  = (!sweep_enable || sweep_rise || (dwell_term && over)) ? base :
                         dwell_term ? sum[PW-1:0] : step_q[c];
            wrap_d[c]  = sweep_enable && !sweep_rise && dwell_term && over;
            acc_d[c]   = phase_sync ? '0 : enable ? acc_q[c] + step_q[c] : acc_q[c];
            // Only quadrant and table index survive past S1.
            s1_d[c]    = (LW+2)'((acc_q[c] + phase_offset[c*PW +: PW]) >> (PW - LW - 2));
            quad       = s1_q[c][LW+1 -: 2];
            idx        = s1_q[c][LW-1:0];
            quad_d[c]  = quad;
            s2_d[c]    = lut[quad[0] ? ~idx : idx];
            s3_d[c]    = quad_q[c][1] ? -s2_q[c] : s2_q[c];
            amp        = (amplitude[c*AW +: AW] > UNITY) ? UNITY : amplitude[c*AW +: AW];
            prod       = (OW+AW+1)'(s3_q[c]) * (OW+AW+1)'($signed({1'b0, amp}));
            y_d[c]     = OW'(prod >>> (AW - 1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q  <= '{default: '0};
            acc_q   <= '{default: '0};
            s1_q    <= '{default: '0};
            quad_q  <= '{default: '0};
            s2_q    <= '{default: '0};
            s3_q    <= '{default: '0};
            y_q     <= '{default: '0};
            wrap_q  <= '0;
            dwell_q <= '0;
            sweep_q <= 1'b0;
            valid_q <= '0;
        end else begin
            step_q  <= step_d;
            acc_q   <= acc_d;
            s1_q    <= s1_d;
            quad_q  <= quad_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
            sweep_q <= sweep_enable;
            valid_q <= {valid_q[2:0], enable};
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign generated_wave[c*OW +: OW] = y_q[c];
    end

    assign wave_valid = valid_q[3];
    assign sweep_wrap = wrap_q;
endmodule

// File: doc/sine_wave_generator_multichannel.md
# sine_wave_generator_multichannel

Parametrised multi-channel direct digital synthesis (DDS) sine source. It is the successor to the single-channel quarter-wave generator and adds four features:
- N independent channels.
- Per-channel phase offset and amplitude scaling.
- Global phase sync.
- A built-in dwell-based linear frequency sweep engine.

It replaces the bench-driven frequency sweep used during characterisation, and drives DAC/modulator paths.

## Interface
Parameters:
- CHANNELS, 2, number of independent output channels
- PHASE_WIDTH, 32, phase accumulator / phase step width
- LUT_ADDRESS_WIDTH, 8, log2 of quarter-wave table depth
- OUTPUT_WIDTH, 16, signed output sample width
- AMPLITUDE_WIDTH, 16, unsigned amplitude word width

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = accumulators advance; 0 = accumulators hold
- phase_sync  in  1  single-cycle pulse; zeroes all accumulators
- phase_step  in  CHANNELS*PHASE_WIDTH  per-channel base step; channel c at [c*PHASE_WIDTH +: PHASE_WIDTH]
- phase_offset  in  CHANNELS*PHASE_WIDTH  per-channel phase offset
- amplitude  in  CHANNELS*AMPLITUDE_WIDTH  per-channel gain; 2^(AMPLITUDE_WIDTH-1) = unity
- sweep_enable  in  1  1 = sweep engine active
- sweep_increment  in  PHASE_WIDTH  step added at each dwell boundary
- sweep_limit  in  PHASE_WIDTH  maximum current step
- sweep_dwell  in  32  cycles per sweep step; 0 is treated as 1
- generated_wave  out  CHANNELS*OUTPUT_WIDTH  signed two's-complement samples
- wave_valid  out  1  generated_wave carries data from enabled accumulator cycles
- sweep_wrap  out  CHANNELS  single-cycle pulse when a channel's sweep reloads

## Operation
Reset:
- All accumulators, current steps, pipeline registers, dwell counter, generated_wave, wave_valid and sweep_wrap are cleared to 0.

Current step (per channel):
- With sweep_enable=0, current_step = phase_step[c], registered every cycle.
- Rising edge of sweep_enable (registered compare) loads current_step = phase_step[c] and clears the dwell counter.
- With sweep_enable=1, the dwell counter counts 0..max(sweep_dwell,1)-1. On its terminal count, each channel updates as follows:
  - If current_step + sweep_increment > sweep_limit (compared in PHASE_WIDTH+1 bits, no overflow), reload phase_step[c] and pulse sweep_wrap[c] for 1 cycle.
  - Otherwise, current_step += sweep_increment.

Accumulator:
- acc <= acc + current_step, modulo 2^PHASE_WIDTH, when enable=1.
- phase_sync=1 forces acc <= 0 on all channels, regardless of enable. Sync has priority over the increment.

Pipeline (per channel, 4 register stages, always advancing):
- S1: ph = acc + phase_offset[c] (mod 2^PHASE_WIDTH).
- S2: quadrant q = ph[MSB -: 2] and index i = next LUT_ADDRESS_WIDTH bits. For q = 1 or 3, the index is mirrored (i = ~i). Register LUT[i] and q.
- S3: negate the LUT value when q = 2 or 3.
- S4: y = (s3 * amp) >>> (AMPLITUDE_WIDTH-1), using an arithmetic shift (floor), where amp = min(amplitude[c], 2^(AMPLITUDE_WIDTH-1)). Register y to generated_wave.

LUT:
- LUT[k] = round((2^(OUTPUT_WIDTH-1)-1) * sin(pi/2*(k+0.5)/2^LUT_ADDRESS_WIDTH)). This is a half-sample-offset quarter wave, so all four quadrants are exactly symmetric.
- Constant table; initial-block or function generation; synthesisable as ROM.

wave_valid:
- wave_valid is enable delayed through a 4-stage shift register.

## Timing
- Latency: generated_wave at edge k+4 reflects the accumulator value registered at edge k.
- Step-to-frequency: a phase_step change reaches the accumulator 1 cycle later (current_step register). Its first effect on output is therefore 6 edges after the input changes.
- phase_sync asserted before edge k: acc = 0 after edge k. The first post-sync sample (LUT[0] phase) appears after edge k+4.
- enable deassert: the accumulator holds, and the output settles to a constant value after 4 cycles. wave_valid falls 4 cycles after enable falls.
- Sweep: with sweep_enable rising before edge e, steps update at edges e+D, e+2D, ..., where D = max(sweep_dwell,1). sweep_wrap is high for exactly the cycle following the reloading edge.
- phase_step, phase_offset and amplitude are live inputs, sampled every cycle with no handshake.
- Asynchronous reset mid-operation clears state immediately. Operation resumes on the first edge after reset_n rises.

## Test plan
Defaults for all scenarios: CHANNELS=2, PHASE_WIDTH=32, LUT_ADDRESS_WIDTH=8, OUTPUT_WIDTH=16.
- Reset: reset_n=0 asserted mid-run -> generated_wave=0, wave_valid=0, sweep_wrap=0 immediately (asynchronously), regardless of clock.
- Quarter step: step=2^30, offset=0, amplitude=32768, enable=1 -> output repeats 101, 32767, -101, -32767; wave_valid rises 4 cycles after enable.
- Half amplitude: as in the quarter-step case with amplitude=16384 -> 50, 16383, -51, -16384. Then amplitude=65535 -> clamped, outputs identical to amplitude=32768.
- Offset: channel 1 with offset=2^30, both channels step=2^30 -> channel 1 outputs 32767, -101, -32767, 101 while channel 0 outputs 101, 32767, -101, -32767.
- Sync: phase_sync pulse mid-run -> 4 cycles later both channels restart at 101 (offset 0). A sync during enable=0 also zeroes the accumulators.
- Sweep: phase_step=0, increment=1000, limit=3000, dwell=10 -> current_step is 0, 1000, 2000, 3000, 0, updating every 10 cycles. sweep_wrap pulses 1 cycle after the 4th boundary (edge e+40), then the sequence repeats. Also check dwell=0 behaves as dwell=1.
